pulse_xfer_arbiter: RTL

Source-side scheduler that shares one toggle-based pulse-crossing channel among `NREQ` requesters in the same clock domain. Single-cycle request events are latched as pending, granted round-robin, and launched as a channel ID plus a toggle on `xfer_tgl`. The arbiter then waits for the destination's returned acknowledge toggle before launching the next transfer. It sits between local event sources and the fast-to-slow pulse synchronizer, and guarantees that only one transfer is in flight at a time.

---
 rtl/pulse_xfer_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/pulse_xfer_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pulse_xfer_pkg.sv
// Shared definitions for the pulse-crossing transfer scheduler:
// FSM state encoding and default sizing constants.
package pulse_xfer_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int GAP_DEFAULT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT_ACK,
        ST_GAP
    } xfer_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after
// the priority pointer wins, searching upward with wrap-around.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            valid
);

    int             idx;
    logic [IDW-1:0] idx_sel;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx       = 0;
        idx_sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_sel = IDW'(idx);
            if (!valid && req[idx_sel]) begin
                valid          = 1'b1;
                grant[idx_sel] = 1'b1;
                grant_idx      = idx_sel;
            end
        end
    end

endmodule

// File: rtl/pulse_xfer_arbiter.sv
// Shares one toggle-based pulse-crossing channel among NREQ local requesters,
// keeping exactly one transfer in flight until the destination acknowledges.
module pulse_xfer_arbiter
    import pulse_xfer_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = $clog2(NREQ),
    parameter int GAP  = GAP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_pulse,
    input  logic            ack_tgl,
    output logic            xfer_tgl,
    output logic [IDW-1:0]  xfer_id,
    output logic [NREQ-1:0] done,
    output logic [NREQ-1:0] drop,
    output logic            busy
);

    localparam int GW = $clog2(GAP + 1) + 1;

    xfer_state_e     state, state_next;
    logic            ack_s0, ack_s1;
    logic [NREQ-1:0] pend;
    logic [IDW-1:0]  ptr;
    logic [GW-1:0]   gap_cnt;

    logic [NREQ-1:0] arb_grant;
    logic [IDW-1:0]  arb_idx;
    logic            arb_valid;
    logic [NREQ-1:0] grant_vec;
    logic            grant_en;
    logic            launch;
    logic            ack_match;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req       (pend),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        launch     = 1'b0;
        ack_match  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_en   = 1'b1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                launch     = 1'b1;
                state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (ack_s1 == xfer_tgl) begin
                    ack_match  = 1'b1;
                    state_next = (GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt >= GW'(GAP)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign grant_vec = grant_en ? arb_grant : '0;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ack_s0 <= 1'b0;
            ack_s1 <= 1'b0;
        end else begin
            state  <= state_next;
            ack_s0 <= ack_tgl;
            ack_s1 <= ack_s0;
        end
    end

    // A new event on the requester being granted re-arms its pending bit,
    // so it is queued again rather than reported as merged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            drop <= '0;
        end else begin
            pend <= (pend & ~grant_vec) | req_pulse;
            drop <= req_pulse & pend & ~grant_vec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_id  <= '0;
            ptr      <= '0;
            xfer_tgl <= 1'b0;
            done     <= '0;
        end else begin
            if (grant_en) begin
                xfer_id <= arb_idx;
                ptr     <= (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            end
            if (launch) begin
                xfer_tgl <= ~xfer_tgl;
            end
            done <= ack_match ? (NREQ'(1) << xfer_id) : '0;
        end
    end

    // The done cycle already counts as the first idle cycle of the gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (ack_match) begin
            gap_cnt <= GW'(1);
        end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

endmodule
